// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte buffer feeding the UART transmitter.
// Reports fill level and a sticky overflow flag; the outputs depend only on registered state.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow
);

    localparam int LB_DEPTH = $clog2(DEPTH);
    localparam logic [LB_DEPTH:0] FULL_COUNT = (LB_DEPTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LB_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LB_DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LB_DEPTH:0]     count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_en, rd_en, clear;

    assign clear     = rst || flush;
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A clear cycle swallows any handshake offered alongside it.
    assign wr_en = in_valid && in_ready && !clear;
    assign rd_en = out_valid && out_ready && !clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + LB_DEPTH'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + LB_DEPTH'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (LB_DEPTH+1)'(1);
                2'b01:   count_d = count_q - (LB_DEPTH+1)'(1);
                default: count_d = count_q;
            endcase
            if (in_valid && !in_ready) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random checks of uart_tx_fifo (DEPTH 16, 8-bit words) against hand-computed values
// and a queue model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready, overflow;
    logic [7:0] in_data, out_data;
    logic [4:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] nxt_wr, exp_rd;
    logic       do_wr, do_rd;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        $display("write %02h count=%0d", d, count);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_overflow", overflow, 0);

        // Single word is visible one cycle after acceptance and holds while stalled.
        push(8'h41);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h41);
        chk("single_count", count, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_data", out_data, 8'h41);
            chk("hold_count", count, 1);
        end
        chk("hold_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("read 41 count=%0d", count);
        chk("single_read_count", count, 0);
        chk("single_read_valid", out_valid, 0);

        // Fill to 16, then one dropped offer.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("full_count", count, 16);
        chk("full_in_ready", in_ready, 0);
        chk("full_overflow_clear", overflow, 0);
        push(8'hFF);
        chk("overflow_count", count, 16);
        chk("overflow_set", overflow, 1);

        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 32'(i));
            $display("read %02h", out_data);
            step();
        end
        out_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_valid_low", out_valid, 0);
        chk("drain_overflow_sticky", overflow, 1);

        // Concurrent traffic at constant occupancy of 5, wrapping pointers several times.
        nxt_wr = 8'h00;
        exp_rd = 8'h00;
        for (int i = 0; i < 5; i++) begin
            push(nxt_wr);
            nxt_wr++;
        end
        chk("preload_count", count, 5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = nxt_wr;
            chk("stream_data", out_data, exp_rd);
            step();
            $display("stream write %02h read %02h count=%0d", nxt_wr, exp_rd, count);
            chk("stream_count", count, 5);
            nxt_wr++;
            exp_rd++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Flush beats a simultaneous read and write.
        push(8'hB0);
        push(8'hB1);
        chk("preflush_count", count, 7);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        $display("flush count=%0d", count);
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_overflow", overflow, 0);
        push(8'h11);
        chk("postflush_data", out_data, 8'h11);
        chk("postflush_count", count, 1);

        // Reset together with flush from a full, overflowed state.
        for (int i = 0; i < 15; i++) push(8'h20 + 8'(i));
        push(8'hEE);
        chk("prerst_count", count, 16);
        chk("prerst_overflow", overflow, 1);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        $display("reset+flush count=%0d", count);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);

        // Random stress against a queue model.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            do_wr = in_valid && (q.size() < 16);
            do_rd = out_ready && (q.size() > 0);
            if (q.size() > 0) chk("stress_data", out_data, q[0]);
            step();
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(in_data);
            chk("stress_count", count, q.size());
            chk("stress_valid", out_valid, q.size() != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
